// File: rtl/srl_cfg_loader_pkg.sv
// Shared constants and types for the SRLC16E configuration loader.
package srl_cfg_loader_pkg;

  // Depth of one SRLC16E primitive; one config lane is this many bits.
  localparam int unsigned SRL_DEPTH = 16;

  // Width of the shift counter (0..SRL_DEPTH-1).
  localparam int unsigned CNT_W = $clog2(SRL_DEPTH);

  // Loader sequencing states.
  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/srl_cfg_loader.sv
// Serial configuration sequencer for banks of SRLC16E trigger/match LUTs.
// Takes one parallel word per handshake and shifts it MSB-first into the
// selected SRL group over SRL_DEPTH clocks, one serial bit per lane.
// All outputs are registered; busy tells match logic to ignore SRL outputs.
module srl_cfg_loader
  import srl_cfg_loader_pkg::*;
#(
  parameter int unsigned NUM_TARGETS = 8,
  parameter int unsigned LANES       = 2,
  parameter int unsigned SEL_W       = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [SEL_W-1:0]           wr_sel,
  input  logic [SRL_DEPTH*LANES-1:0] wr_data,
  output logic [NUM_TARGETS-1:0]     srl_ce,
  output logic [LANES-1:0]           srl_d,
  output logic                       busy,
  output logic                       done,
  output logic                       sel_err
);

  localparam int unsigned DATA_W = SRL_DEPTH * LANES;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SRL_DEPTH - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  word_q;
  logic [SEL_W-1:0]   sel_q;

  logic               accept;
  logic [DATA_W-1:0]  src_word;
  logic [SEL_W-1:0]   src_sel;
  logic [CNT_W-1:0]   src_idx;
  logic [SRL_DEPTH-1:0] lane_word;
  logic [NUM_TARGETS-1:0] ce_next;
  logic [LANES-1:0]   d_next;

  assign accept = wr_valid & wr_ready;

  // Pick the word/select/bit index for the shift that the next clock will present:
  // in idle that is bit 0 of the incoming word, in shift it is the following bit.
  always_comb begin
    src_word = word_q;
    src_sel  = sel_q;
    src_idx  = cnt_q + CNT_W'(1);
    if (state_q == StIdle) begin
      src_word = wr_data;
      src_sel  = wr_sel;
      src_idx  = '0;
    end
  end

  // One-hot decode of the target; an out-of-range select decodes to all zeros.
  always_comb begin
    ce_next = '0;
    for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
      if (src_sel == SEL_W'(i)) begin
        ce_next[i] = 1'b1;
      end
    end
  end

  // MSB-first serial bit per lane: lane L sends word[16*L + 15 - k] at shift k.
  always_comb begin
    d_next    = '0;
    lane_word = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_word = src_word[SRL_DEPTH*l +: SRL_DEPTH];
      d_next[l] = lane_word[CNT_MAX - src_idx];
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      word_q   <= '0;
      sel_q    <= '0;
      wr_ready <= 1'b0;
      srl_ce   <= '0;
      srl_d    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sel_err  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done    <= 1'b0;
          sel_err <= 1'b0;
          srl_ce  <= '0;
          srl_d   <= '0;
          busy    <= 1'b0;
          if (accept) begin
            word_q   <= wr_data;
            sel_q    <= wr_sel;
            cnt_q    <= '0;
            state_q  <= StShift;
            wr_ready <= 1'b0;
            busy     <= 1'b1;
            srl_ce   <= ce_next;
            srl_d    <= d_next;
          end else begin
            wr_ready <= 1'b1;
          end
        end
        StShift: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            state_q <= StDone;
            srl_ce  <= '0;
            srl_d   <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            // src_sel is sel_q here, so an empty decode means out of range.
            sel_err <= ~|ce_next;
          end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            srl_ce <= ce_next;
            srl_d  <= d_next;
          end
        end
        StDone: begin
          done     <= 1'b0;
          sel_err  <= 1'b0;
          wr_ready <= 1'b1;
          state_q  <= StIdle;
        end
        default: begin
          state_q  <= StIdle;
          cnt_q    <= '0;
          wr_ready <= 1'b0;
          srl_ce   <= '0;
          srl_d    <= '0;
          busy     <= 1'b0;
          done     <= 1'b0;
          sel_err  <= 1'b0;
        end
      endcase
    end
  end

  // Structural guarantees relied on by the match units.
  srl_ce_onehot0: assert property (@(posedge clock) disable iff (reset) $onehot0(srl_ce));
  srl_ce_in_busy: assert property (@(posedge clock) disable iff (reset) (srl_ce != '0) |-> busy);

endmodule
